// File: rtl/alu_resp_packer_pkg.sv
// Shared constants and types for the ALU response packer.
// Holds the status codes, header size and packer state encoding.
package alu_resp_packer_pkg;

  localparam logic [7:0] RESP_STATUS_OK  = 8'h00;
  localparam logic [7:0] RESP_STATUS_ERR = 8'h01;
  localparam int         RESP_HDR_BYTES  = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OPC,
    ST_STAT,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_PAYLOAD
  } pack_state_e;

  // Total packet length of an OK response, as carried in the length field.
  function automatic logic [15:0] resp_len(input int result_bytes);
    return 16'(RESP_HDR_BYTES + result_bytes);
  endfunction

endpackage

// File: rtl/alu_resp_packer.sv
// Frames one ALU result into a little-endian byte packet for uart_tx.
// OK: opcode, 0x00, len_lo, len_hi, result bytes. Error: opcode, 0x01, 0x04, 0x00.
module alu_resp_packer
  import alu_resp_packer_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int RESULT_BYTES = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  res_valid_i,
  output logic                  res_ready_o,
  input  logic [7:0]            res_opcode_i,
  input  logic [31:0]           res_data_i,
  input  logic                  res_err_i,
  output logic [DATA_WIDTH-1:0] m_axis_tdata_o,
  output logic                  m_axis_tvalid_o,
  input  logic                  m_axis_tready_i,
  output logic                  busy_o,
  output pack_state_e           dbg_state_o
);

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // Once m_axis_tvalid_o is raised it stays high with m_axis_tdata_o stable
  // until the byte is taken; results are only captured when res_ready_o is high.

  localparam logic [15:0] LEN     = resp_len(RESULT_BYTES);
  localparam logic [1:0]  CNT_END = 2'(RESULT_BYTES - 1);

  pack_state_e           state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [7:0]            opc_q, opc_d;
  logic [31:0]           data_q, data_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] tdata_q;
  logic                  tvalid_q;
  logic [7:0]            byte_d;
  logic                  fire;

  assign fire = tvalid_q && m_axis_tready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opc_d   = opc_q;
    data_d  = data_q;
    err_d   = err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (res_valid_i) begin
          opc_d   = res_opcode_i;
          data_d  = res_data_i;
          err_d   = res_err_i;
          cnt_d   = 2'd0;
          state_d = ST_OPC;
        end
      end
      ST_OPC:    if (fire) state_d = ST_STAT;
      ST_STAT:   if (fire) state_d = ST_LEN_LO;
      ST_LEN_LO: if (fire) state_d = ST_LEN_HI;
      ST_LEN_HI: begin
        if (fire) begin
          cnt_d   = 2'd0;
          state_d = err_q ? ST_IDLE : ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (fire) begin
          if (cnt_q == CNT_END) begin
            cnt_d   = 2'd0;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Byte for the next cycle, selected from the next state so tdata is registered.
  always_comb begin
    byte_d = 8'h00;
    unique case (state_d)
      ST_OPC:     byte_d = opc_d;
      ST_STAT:    byte_d = err_d ? RESP_STATUS_ERR : RESP_STATUS_OK;
      ST_LEN_LO:  byte_d = err_d ? 8'(RESP_HDR_BYTES) : LEN[7:0];
      ST_LEN_HI:  byte_d = err_d ? 8'h00 : LEN[15:8];
      ST_PAYLOAD: byte_d = data_d[{cnt_d, 3'b000} +: 8];
      default:    byte_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      opc_q    <= 8'h00;
      data_q   <= 32'h0;
      err_q    <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opc_q    <= opc_d;
      data_q   <= data_d;
      err_q    <= err_d;
      tdata_q  <= DATA_WIDTH'(byte_d);
      tvalid_q <= (state_d != ST_IDLE);
    end
  end

  assign m_axis_tdata_o  = tdata_q;
  assign m_axis_tvalid_o = tvalid_q;
  assign res_ready_o     = (state_q == ST_IDLE);
  assign busy_o          = (state_q != ST_IDLE);
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_alu_resp_packer.sv
// Self-checking bench for alu_resp_packer: a byte-list reference model,
// random backpressure, mid-packet reset and a 2-byte-result build.
module tb_alu_resp_packer;
  import alu_resp_packer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        res_valid = 1'b0;
  logic        res_ready;
  logic [7:0]  res_opcode = 8'h00;
  logic [31:0] res_data = 32'h0;
  logic        res_err = 1'b0;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready = 1'b0;
  logic        busy;
  pack_state_e dbg_state;

  logic        res_valid2 = 1'b0;
  logic        res_ready2;
  logic [7:0]  res_opcode2 = 8'h00;
  logic [31:0] res_data2 = 32'h0;
  logic        res_err2 = 1'b0;
  logic [7:0]  tdata2;
  logic        tvalid2;
  logic        tready2 = 1'b0;
  logic        busy2;
  pack_state_e dbg_state2;

  logic [7:0]  exp_q[$];
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  alu_resp_packer #(.DATA_WIDTH(8), .RESULT_BYTES(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .res_valid_i(res_valid), .res_ready_o(res_ready),
    .res_opcode_i(res_opcode), .res_data_i(res_data), .res_err_i(res_err),
    .m_axis_tdata_o(tdata), .m_axis_tvalid_o(tvalid), .m_axis_tready_i(tready),
    .busy_o(busy), .dbg_state_o(dbg_state)
  );

  alu_resp_packer #(.DATA_WIDTH(8), .RESULT_BYTES(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .res_valid_i(res_valid2), .res_ready_o(res_ready2),
    .res_opcode_i(res_opcode2), .res_data_i(res_data2), .res_err_i(res_err2),
    .m_axis_tdata_o(tdata2), .m_axis_tvalid_o(tvalid2), .m_axis_tready_i(tready2),
    .busy_o(busy2), .dbg_state_o(dbg_state2)
  );

  // Reference: the packet as a plain list of bytes.
  function automatic void build(input logic [7:0] op, input logic [31:0] d,
                                input logic err, input int rb);
    int len;
    len = 4 + rb;
    exp_q.push_back(op);
    exp_q.push_back(err ? 8'h01 : 8'h00);
    exp_q.push_back(err ? 8'h04 : 8'(len % 256));
    exp_q.push_back(err ? 8'h00 : 8'(len / 256));
    if (!err)
      for (int i = 0; i < rb; i++) exp_q.push_back(8'((d >> (8 * i)) & 32'hFF));
  endfunction

  task automatic run_packet(input logic [7:0] op, input logic [31:0] d, input logic err,
                            input int stall_pct, input bit corrupt, input string tag);
    int n_exp, cycles;
    bit have_prev;
    logic [7:0] prev, exp;
    exp_q.delete();
    build(op, d, err, 4);
    n_exp = exp_q.size();
    @(posedge clk); #1;
    res_valid = 1'b1; res_opcode = op; res_data = d; res_err = err; tready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (res_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s accept_ready: ready=%b busy=%b, required ready=1 busy=0", tag, res_ready, busy);
    end
    @(posedge clk); #1;
    res_valid = 1'b0;
    if (corrupt) begin
      res_data = 32'h0; res_opcode = 8'($urandom); res_err = ~err;
    end
    cycles = 0; have_prev = 0; prev = 8'h00;
    while (exp_q.size() > 0 && cycles < 400) begin
      tready = ($urandom_range(0, 99) >= stall_pct);
      @(negedge clk);
      n_checks++;
      if (tvalid !== 1'b1 || res_ready !== 1'b0 || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL %s valid_hold: tvalid=%b ready=%b busy=%b, required 1 0 1", tag, tvalid, res_ready, busy);
      end
      if (have_prev) begin
        n_checks++;
        if (tdata !== prev) begin
          n_fail++;
          $display("FAIL %s stall_stable: tdata=%h, required %h", tag, tdata, prev);
        end
      end
      if (tready) begin
        exp = exp_q.pop_front();
        n_checks++;
        if (tdata !== exp) begin
          n_fail++;
          $display("FAIL %s byte%0d: tdata=%h, required %h", tag, n_exp - exp_q.size() - 1, tdata, exp);
        end
        have_prev = 0;
      end else begin
        have_prev = 1; prev = tdata;
      end
      @(posedge clk); #1;
      cycles++;
    end
    tready = 1'b0;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s timeout: %0d bytes outstanding, required 0", tag, exp_q.size());
      exp_q.delete();
    end
    if (stall_pct == 0) begin
      n_checks++;
      if (cycles != n_exp) begin
        n_fail++;
        $display("FAIL %s beats: cycles=%0d, required %0d", tag, cycles, n_exp);
      end
    end
    @(negedge clk);
    n_checks++;
    if (res_ready !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL %s ready_after_last: ready=%b tvalid=%b busy=%b, required 1 0 0", tag, res_ready, tvalid, busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (res_ready !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0 || tdata !== 8'h00 ||
        res_ready2 !== 1'b1 || tvalid2 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: ready=%b tvalid=%b busy=%b tdata=%h ready2=%b tvalid2=%b busy2=%b, required 1 0 0 00 1 0 0",
               res_ready, tvalid, busy, tdata, res_ready2, tvalid2, busy2);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (res_ready !== 1'b1 || tvalid !== 1'b0 || busy !== 1'b0 || tdata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release: ready=%b tvalid=%b busy=%b tdata=%h, required 1 0 0 00",
               res_ready, tvalid, busy, tdata);
    end
  endtask

  task automatic test_ok_packet();
    run_packet(8'h10, 32'hDEADBEEF, 1'b0, 0, 1'b0, "ok");
  endtask

  task automatic test_err_packet();
    run_packet(8'h7F, $urandom, 1'b1, 0, 1'b0, "err");
  endtask

  task automatic test_backpressure();
    run_packet(8'h10, 32'hDEADBEEF, 1'b0, 50, 1'b1, "bp");
    for (int i = 0; i < 6; i++)
      run_packet(8'($urandom), $urandom, ($urandom_range(0, 3) == 0), 30, 1'b1, "rand");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      run_packet(8'($urandom), $urandom, 1'(i == 1), 0, 1'b0, "b2b");
  endtask

  task automatic test_reset_mid();
    int accepted;
    accepted = 0;
    @(posedge clk); #1;
    res_valid = 1'b1; res_opcode = 8'h55; res_data = 32'hCAFEF00D; res_err = 1'b0; tready = 1'b1;
    @(posedge clk); #1;
    res_valid = 1'b0;
    for (int c = 0; c < 20 && accepted < 3; c++) begin
      @(negedge clk);
      if (tvalid) accepted++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (tvalid !== 1'b1 || accepted != 3) begin
      n_fail++;
      $display("FAIL rst_mid_pre: tvalid=%b accepted=%0d, required 1 3", tvalid, accepted);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (tvalid !== 1'b0 || busy !== 1'b0 || res_ready !== 1'b1 || tdata !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_async: tvalid=%b busy=%b ready=%b tdata=%h, required 0 0 1 00",
               tvalid, busy, res_ready, tdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (tvalid !== 1'b0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_mid_no_resume: tvalid=%b busy=%b, required 0 0", tvalid, busy);
      end
    end
    tready = 1'b0;
    run_packet(8'h20, 32'h00000001, 1'b0, 0, 1'b0, "post_rst");
  endtask

  task automatic test_rb2();
    int cycles, n_exp;
    logic [7:0] exp;
    exp_q.delete();
    build(8'h11, 32'h1234ABCD, 1'b0, 2);
    n_exp = exp_q.size();
    @(posedge clk); #1;
    res_valid2 = 1'b1; res_opcode2 = 8'h11; res_data2 = 32'h1234ABCD; res_err2 = 1'b0; tready2 = 1'b1;
    @(posedge clk); #1;
    res_valid2 = 1'b0;
    cycles = 0;
    while (exp_q.size() > 0 && cycles < 50) begin
      @(negedge clk);
      exp = exp_q.pop_front();
      n_checks++;
      if (tvalid2 !== 1'b1 || tdata2 !== exp) begin
        n_fail++;
        $display("FAIL rb2 byte%0d: tvalid=%b tdata=%h, required 1 %h", cycles, tvalid2, tdata2, exp);
      end
      @(posedge clk); #1;
      cycles++;
    end
    tready2 = 1'b0;
    @(negedge clk);
    n_checks++;
    if (cycles != n_exp || tvalid2 !== 1'b0 || res_ready2 !== 1'b1) begin
      n_fail++;
      $display("FAIL rb2_end: beats=%0d tvalid=%b ready=%b, required %0d 0 1", cycles, tvalid2, res_ready2, n_exp);
    end
  endtask

  initial begin
    test_reset();
    test_ok_packet();
    test_err_packet();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_rb2();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
